stopwatch_ctrl: RTL and testbench
=================================

STOPWATCH_CTRL -- requirements
Module: stopwatch_ctrl

Interface
REQ-001 Parameter DIV, default 10, ck cycles per count tick; legal range 2..65535.
REQ-002 ck  input  1  system clock; all state changes on rising edge.
REQ-003 res  input  1  reset; asynchronous, active-low; one clock, no other clock or reset.
REQ-004 start  input  1  start/resume button level, synchronous to ck.
REQ-005 stop  input  1  stop/pause button level, synchronous to ck.
REQ-006 lap  input  1  lap / clear button level, synchronous to ck.
REQ-007 cnt_q  input  4  current value of the stopwatch counter datapath.
REQ-008 cnt_en  output  1  one-cycle count-enable pulse to the datapath.
REQ-009 cnt_clr  output  1  one-cycle synchronous clear pulse to the datapath.
REQ-010 disp  output  4  display value: frozen lap value in LAP, else cnt_q.
REQ-011 state  output  2  FSM state code: IDLE=0, RUN=1, PAUSE=2, LAP=3.

Function
REQ-012 Each button SHALL be edge-detected with a registered previous value; only a 0->1 transition is an event.
REQ-013 An event sampled at edge N SHALL change state at edge N+1 (state output visible one cycle after sampling).
REQ-014 Simultaneous events SHALL be prioritised stop > start > lap; lower-priority events in that cycle are discarded.
REQ-015 IDLE: start -> RUN with prescaler cleared to 0; stop and lap ignored.
REQ-016 RUN: stop -> PAUSE; lap -> LAP with lap_reg loaded from cnt_q in the same edge; start ignored.
REQ-017 LAP: counting continues; lap -> RUN (display released); stop -> PAUSE; start ignored.
REQ-018 PAUSE: start -> RUN with prescaler residue preserved; lap -> IDLE with cnt_clr high for exactly one cycle and prescaler cleared; stop ignored.
REQ-019 Prescaler (16-bit) SHALL increment only in RUN or LAP, wrap DIV-1 -> 0, and hold in IDLE and PAUSE.
REQ-020 cnt_en SHALL be registered and high for exactly one cycle following each prescaler value DIV-1 in RUN/LAP; never high in IDLE or PAUSE.
REQ-021 First cnt_en after IDLE->RUN SHALL occur DIV cycles after state becomes RUN.
REQ-022 A stop event in the cycle the prescaler reaches DIV-1 SHALL still emit that cnt_en pulse; no further pulses until resumed.
REQ-023 disp SHALL equal lap_reg while state==LAP, otherwise cnt_q combinationally.
REQ-024 cnt_en and cnt_clr SHALL never be high in the same cycle.
REQ-025 Counter wrap-around (cnt_q 15->0 or 9->0) is the datapath's concern; controller behaviour SHALL be independent of cnt_q value.

Reset
REQ-026 While res=0: state=IDLE, prescaler=0, lap_reg=0, cnt_en=0, cnt_clr=0, disp=cnt_q.
REQ-027 Edge-detect registers SHALL reset to 1, so a button held through reset release produces no event until released and pressed again.
REQ-028 Reset asserted mid-operation (any state, any prescaler value) SHALL take effect immediately, aborting any pending pulse.

Verification (DIV=4)
REQ-029 res pulse low then high, start pressed 1 cycle -> state 0->1 next edge, cnt_en pulses every 4 cycles, first 4 cycles after RUN.
REQ-030 RUN, cnt_q=5, lap pressed -> state=3, disp holds 5 while cnt_q advances to 7; lap again -> state=1, disp=cnt_q.
REQ-031 RUN, stop at prescaler=2 -> state=2, no cnt_en; start -> state=1, next cnt_en after 2 cycles (residue kept).
REQ-032 PAUSE, lap pressed -> cnt_clr high exactly one cycle, state=0; later start -> RUN, first cnt_en after 4 cycles.
REQ-033 RUN, start+stop+lap rise same cycle -> state=2 only; button held high across reset release -> no transition until re-pressed.
REQ-034 res low mid-LAP with prescaler=3 -> immediately state=0, cnt_en=0, disp=cnt_q, lap_reg=0.

Source files
------------

// File: rtl/stopwatch_ctrl_if.sv
// Stopwatch controller bundle: the three button levels and counter readback
// from the system side, plus the pulses, display value and state code the
// controller returns.
interface stopwatch_ctrl_if;
    logic       start;
    logic       stop;
    logic       lap;
    logic [3:0] cnt_q;
    logic       cnt_en;
    logic       cnt_clr;
    logic [3:0] disp;
    logic [1:0] state;

    // System side: presses buttons, supplies the counter value, observes outputs.
    modport master (
        output start, stop, lap, cnt_q,
        input  cnt_en, cnt_clr, disp, state
    );

    // Controller side.
    modport slave (
        input  start, stop, lap, cnt_q,
        output cnt_en, cnt_clr, disp, state
    );
endinterface

// File: rtl/stopwatch_ctrl.sv
// Stopwatch controller: edge-detects three button levels, runs an
// IDLE/RUN/PAUSE/LAP state machine and a DIV-cycle prescaler that issues
// one-cycle count-enable pulses to an external counter datapath. A lap
// snapshot of the counter is frozen onto the display while in LAP.
module stopwatch_ctrl #(
    parameter int unsigned DIV = 10
) (
    input  logic             ck,
    input  logic             res,
    stopwatch_ctrl_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_LAP   = 2'd3
    } state_t;

    localparam logic [15:0] PRESC_LAST = 16'(DIV - 32'd1);

    // Button history and registered rising-edge events.
    logic        start_prev_r;
    logic        stop_prev_r;
    logic        lap_prev_r;
    logic        start_ev_r;
    logic        stop_ev_r;
    logic        lap_ev_r;

    // Controller state.
    state_t      state_r;
    logic [15:0] presc_r;
    logic [3:0]  lap_r;
    logic        cnt_en_r;
    logic        cnt_clr_r;

    // Combinational decisions for the next edge.
    state_t      state_nxt_s;
    logic        load_lap_s;
    logic        clr_s;
    logic        presc_clear_s;
    logic        counting_s;
    logic        presc_last_s;
    logic [15:0] presc_nxt_s;
    logic        tick_s;

    // Edge detection: history resets high so a button held through reset
    // release is not mistaken for a fresh press.
    always_ff @(posedge ck or negedge res) begin
        if (!res) begin
            start_prev_r <= 1'b1;
            stop_prev_r  <= 1'b1;
            lap_prev_r   <= 1'b1;
            start_ev_r   <= 1'b0;
            stop_ev_r    <= 1'b0;
            lap_ev_r     <= 1'b0;
        end else begin
            start_ev_r   <= bus.start & ~start_prev_r;
            stop_ev_r    <= bus.stop  & ~stop_prev_r;
            lap_ev_r     <= bus.lap   & ~lap_prev_r;
            start_prev_r <= bus.start;
            stop_prev_r  <= bus.stop;
            lap_prev_r   <= bus.lap;
        end
    end

    // Next-state selection; within each state stop outranks start outranks
    // lap, and events with no meaning in the current state are dropped.
    always_comb begin
        state_nxt_s   = state_r;
        load_lap_s    = 1'b0;
        clr_s         = 1'b0;
        presc_clear_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start_ev_r) begin
                    state_nxt_s   = ST_RUN;
                    presc_clear_s = 1'b1;
                end else begin
                    state_nxt_s   = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (stop_ev_r) begin
                    state_nxt_s = ST_PAUSE;
                end else if (lap_ev_r) begin
                    state_nxt_s = ST_LAP;
                    load_lap_s  = 1'b1;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            ST_LAP: begin
                if (stop_ev_r) begin
                    state_nxt_s = ST_PAUSE;
                end else if (lap_ev_r) begin
                    state_nxt_s = ST_RUN;
                end else begin
                    state_nxt_s = ST_LAP;
                end
            end
            ST_PAUSE: begin
                if (start_ev_r) begin
                    state_nxt_s   = ST_RUN;
                end else if (lap_ev_r) begin
                    state_nxt_s   = ST_IDLE;
                    clr_s         = 1'b1;
                    presc_clear_s = 1'b1;
                end else begin
                    state_nxt_s   = ST_PAUSE;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    assign counting_s   = (state_r == ST_RUN) || (state_r == ST_LAP);
    assign presc_last_s = (presc_r >= PRESC_LAST);

    // Prescaler: advances while counting and wraps with a tick at DIV-1. On
    // the edge that pauses it, the value is frozen so a resume picks up the
    // residue; a tick due on that same edge is still issued and consumed.
    always_comb begin
        presc_nxt_s = presc_r;
        tick_s      = 1'b0;
        if (presc_clear_s) begin
            presc_nxt_s = 16'd0;
        end else if (counting_s) begin
            if (presc_last_s) begin
                presc_nxt_s = 16'd0;
                tick_s      = 1'b1;
            end else if (state_nxt_s == ST_PAUSE) begin
                presc_nxt_s = presc_r;
            end else begin
                presc_nxt_s = presc_r + 16'd1;
            end
        end else begin
            presc_nxt_s = presc_r;
        end
    end

    // State, prescaler, lap snapshot and registered output pulses.
    always_ff @(posedge ck or negedge res) begin
        if (!res) begin
            state_r   <= ST_IDLE;
            presc_r   <= 16'd0;
            lap_r     <= 4'd0;
            cnt_en_r  <= 1'b0;
            cnt_clr_r <= 1'b0;
        end else begin
            state_r   <= state_nxt_s;
            presc_r   <= presc_nxt_s;
            cnt_en_r  <= tick_s;
            cnt_clr_r <= clr_s;
            if (load_lap_s) begin
                lap_r <= bus.cnt_q;
            end else begin
                lap_r <= lap_r;
            end
        end
    end

    assign bus.cnt_en  = cnt_en_r;
    assign bus.cnt_clr = cnt_clr_r;
    assign bus.state   = state_r;
    assign bus.disp    = (state_r == ST_LAP) ? lap_r : bus.cnt_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Stopwatch controller bench: directed scenarios followed by random button
// activity. A driver applies stimulus and pushes the reference model's
// expected outputs into a queue; a monitor pops and compares on each
// falling edge.
module tb_stopwatch_ctrl;

    localparam int DIV     = 4;
    localparam int S_IDLE  = 0;
    localparam int S_RUN   = 1;
    localparam int S_PAUSE = 2;
    localparam int S_LAP   = 3;

    logic ck  = 1'b0;
    logic res = 1'b0;

    stopwatch_ctrl_if bus ();

    stopwatch_ctrl #(.DIV(DIV)) dut (
        .ck  (ck),
        .res (res),
        .bus (bus)
    );

    always #5 ck = ~ck;

    typedef struct {
        logic [1:0] st;
        logic       en;
        logic       clr;
        logic [3:0] disp;
        int         cyc;
    } exp_t;

    exp_t exp_q[$];

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    // Reference model: stopwatch mode, phase within the current count
    // period, frozen lap value, and the counter value the datapath holds.
    int m_state = S_IDLE;
    int m_phase = 0;
    int m_lap   = 0;
    int m_cnt   = 0;
    bit m_en    = 1'b0;
    bit m_clr   = 1'b0;
    bit m_prev_s = 1'b1, m_prev_p = 1'b1, m_prev_l = 1'b1;
    bit m_pend_s = 1'b0, m_pend_p = 1'b0, m_pend_l = 1'b0;
    bit a_s = 1'b0, a_p = 1'b0, a_l = 1'b0, a_res = 1'b0;

    function automatic void model_reset();
        m_state  = S_IDLE;
        m_phase  = 0;
        m_lap    = 0;
        m_en     = 1'b0;
        m_clr    = 1'b0;
        m_prev_s = 1'b1; m_prev_p = 1'b1; m_prev_l = 1'b1;
        m_pend_s = 1'b0; m_pend_p = 1'b0; m_pend_l = 1'b0;
    endfunction

    function automatic void model_clock();
        int old_state;
        int old_cnt;
        bit ev_s, ev_p, ev_l;
        old_state = m_state;
        old_cnt   = m_cnt;
        ev_s = m_pend_s; ev_p = m_pend_p; ev_l = m_pend_l;
        // the datapath acts on the pulses issued in the previous cycle
        if (m_clr) m_cnt = 0;
        else if (m_en) m_cnt = (m_cnt + 1) % 10;
        m_en  = 1'b0;
        m_clr = 1'b0;
        // presses seen now take effect one edge later
        m_pend_s = a_s && !m_prev_s; m_prev_s = a_s;
        m_pend_p = a_p && !m_prev_p; m_prev_p = a_p;
        m_pend_l = a_l && !m_prev_l; m_prev_l = a_l;
        if (old_state == S_IDLE) begin
            if (ev_s) begin m_state = S_RUN; m_phase = 0; end
        end else if (old_state == S_RUN) begin
            if (ev_p) m_state = S_PAUSE;
            else if (ev_l) begin m_state = S_LAP; m_lap = old_cnt; end
        end else if (old_state == S_LAP) begin
            if (ev_p) m_state = S_PAUSE;
            else if (ev_l) m_state = S_RUN;
        end else begin
            if (ev_s) m_state = S_RUN;
            else if (ev_l) begin m_state = S_IDLE; m_clr = 1'b1; m_phase = 0; end
        end
        if (old_state == S_RUN || old_state == S_LAP) begin
            if (m_phase == DIV - 1) begin
                m_phase = 0;
                m_en    = 1'b1;
            end else if (m_state != S_PAUSE) begin
                m_phase = m_phase + 1;
            end
        end
    endfunction

    // One clock: advance the model over the edge, then drive the next inputs
    // and queue the outputs expected for the cycle that follows.
    task automatic cycle(input bit rs, input bit s, input bit p, input bit l);
        exp_t e;
        @(posedge ck);
        if (a_res) model_clock();
        else model_reset();
        #1;
        res = rs; a_res = rs;
        if (!rs) model_reset();
        bus.start = s; bus.stop = p; bus.lap = l;
        a_s = s; a_p = p; a_l = l;
        bus.cnt_q = 4'(m_cnt);
        cyc++;
        e.st   = 2'(m_state);
        e.en   = m_en;
        e.clr  = m_clr;
        e.disp = (m_state == S_LAP) ? 4'(m_lap) : 4'(m_cnt);
        e.cyc  = cyc;
        exp_q.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic press(input bit s, input bit p, input bit l);
        cycle(1'b1, s, p, l);
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    // Monitor: compare every queued expectation against the live outputs.
    initial begin
        exp_t e;
        forever begin
            @(negedge ck);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n_cmp++;
                if (bus.state !== e.st) begin
                    n_err++;
                    $display("FAIL state cycle %0d: got %0d expected %0d", e.cyc, bus.state, e.st);
                end
                n_cmp++;
                if (bus.cnt_en !== e.en) begin
                    n_err++;
                    $display("FAIL cnt_en cycle %0d: got %b expected %b", e.cyc, bus.cnt_en, e.en);
                end
                n_cmp++;
                if (bus.cnt_clr !== e.clr) begin
                    n_err++;
                    $display("FAIL cnt_clr cycle %0d: got %b expected %b", e.cyc, bus.cnt_clr, e.clr);
                end
                n_cmp++;
                if (bus.disp !== e.disp) begin
                    n_err++;
                    $display("FAIL disp cycle %0d: got %0d expected %0d", e.cyc, bus.disp, e.disp);
                end
            end
        end
    end

    // Stimulus: directed scenarios, then randomized button activity.
    initial begin
        bit r_s, r_p, r_l;
        int guard;
        bus.start = 1'b0; bus.stop = 1'b0; bus.lap = 1'b0; bus.cnt_q = 4'd0;

        // start held through reset release: no event until re-pressed
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) cycle(1'b1, 1'b1, 1'b0, 1'b0);
        idle(2);

        // start, run through several count periods
        press(1'b1, 1'b0, 1'b0);
        idle(12);

        // lap freeze and release
        press(1'b0, 1'b0, 1'b1);
        idle(9);
        press(1'b0, 1'b0, 1'b1);
        idle(3);

        // stop mid-period, resume with residue, stop again
        press(1'b0, 1'b1, 1'b0);
        idle(4);
        press(1'b1, 1'b0, 1'b0);
        idle(6);
        press(1'b0, 1'b1, 1'b0);
        idle(2);

        // clear from pause, restart
        press(1'b0, 1'b0, 1'b1);
        idle(3);
        press(1'b1, 1'b0, 1'b0);
        idle(7);

        // all three buttons together while running: stop wins
        press(1'b1, 1'b1, 1'b1);
        idle(3);
        press(1'b1, 1'b0, 1'b0);
        idle(3);

        // enter LAP and reset while the prescaler sits at DIV-1
        press(1'b0, 1'b0, 1'b1);
        guard = 0;
        while (!(m_state == S_LAP && m_phase == DIV - 2) && guard < 40) begin
            idle(1);
            guard++;
        end
        if (guard >= 40) begin
            n_err++;
            $display("FAIL lap_reset_setup: got no LAP at phase %0d within 40 cycles expected reached", DIV - 2);
        end else begin
            cycle(1'b0, 1'b0, 1'b0, 1'b0);
        end
        cycle(1'b0, 1'b0, 1'b0, 1'b0);
        idle(3);

        // random button activity with occasional resets
        r_s = 1'b0; r_p = 1'b0; r_l = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 3) == 0) r_s = ~r_s;
            if ($urandom_range(0, 5) == 0) r_p = ~r_p;
            if ($urandom_range(0, 4) == 0) r_l = ~r_l;
            if ($urandom_range(0, 399) == 0) begin
                cycle(1'b0, r_s, r_p, r_l);
                cycle(1'b0, r_s, r_p, r_l);
            end else begin
                cycle(1'b1, r_s, r_p, r_l);
            end
        end
        idle(2);

        repeat (3) @(posedge ck);
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
